// File: rtl/ir_period_counter.sv
// ir_period_counter: programmable IR timebase with prescaler and wrap/one-shot/up-down modes; IR_CAPTURE_EN adds count capture
module ir_period_counter #(
  parameter int WIDTH       = 11,
  parameter int PRESCALE_W  = 8,
  parameter int DEFAULT_TOP = 1750
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      top,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  dir,
  output logic                  running,
  input  logic                  capture_in,
  output logic [WIDTH-1:0]      capture_val,
  output logic                  capture_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  state;
  logic [1:0]              mode_q;
  logic [WIDTH-1:0]        top_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic [PRESCALE_W-1:0]   psc;
  logic [WIDTH-1:0]        up1;
  logic [WIDTH-1:0]        dn1;
  logic [WIDTH-1:0]        nxt_count;
  logic                    nxt_tick;
  logic                    nxt_dir;
  logic                    at_top;
  logic                    step;
  assign running = state == RUN;
  assign step    = psc == prescale_q;
  assign up1     = count + WIDTH'(1);
  assign dn1     = count - WIDTH'(1);
  assign at_top  = count >= top_q;
  // next count/tick/dir for one step; mode 11 falls through to free-run wrap
  always_comb begin
    nxt_count = at_top ? '0 : up1;
    nxt_tick  = at_top;
    nxt_dir   = dir;
    if (mode_q == 2'b01) begin
      nxt_count = at_top ? top_q : up1;
      nxt_tick  = at_top || up1 == top_q;
    end else if (mode_q == 2'b10) begin
      nxt_count = dir ? (at_top ? top_q : up1) : (count == '0 ? '0 : dn1);
      nxt_tick  = dir ? (at_top || up1 == top_q) : (count <= WIDTH'(1));
      nxt_dir   = dir ^ nxt_tick;
    end
  end
  // control FSM, prescaler and counter with priority rst > clear > start > step
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      tick       <= 1'b0;
      dir        <= 1'b1;
      psc        <= '0;
      top_q      <= WIDTH'(DEFAULT_TOP);
      mode_q     <= 2'b00;
      prescale_q <= '0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      tick  <= 1'b0;
      dir   <= 1'b1;
      psc   <= '0;
    end else if (start) begin
      mode_q     <= mode;
      top_q      <= top;
      prescale_q <= prescale;
      state      <= RUN;
      count      <= '0;
      tick       <= 1'b0;
      dir        <= 1'b1;
      psc        <= '0;
    end else begin
      tick <= running && en && step && nxt_tick;
      if (running && en) begin
        psc <= step ? '0 : psc + PRESCALE_W'(1);
        if (step) begin
          count <= nxt_count;
          dir   <= nxt_dir;
          if (mode_q == 2'b01 && nxt_tick) state <= DONE;
        end
      end
    end
  end
`ifdef IR_CAPTURE_EN
  logic [3:0] sync;
  // two-flop synchroniser, one retiming flop and edge history; capture the pre-edge count on a rising strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync          <= '0;
      capture_val   <= '0;
      capture_valid <= 1'b0;
    end else begin
      sync          <= {sync[2:0], capture_in};
      capture_valid <= sync[2] & ~sync[3];
      if (sync[2] & ~sync[3]) capture_val <= count;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign capture_val    = '0;
  assign capture_valid  = 1'b0;
`endif
endmodule
